// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: FIXED/INCR/WRAP bursts, byte strobes, independent read and
// write channels, and a SLVERR address window. Single-ported write, async read.
module axi4_slave_mem #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] ERR_BASE   = '0,
    parameter logic [ADDR_WIDTH-1:0] ERR_SIZE   = '0
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_W - 1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // Borrow of (addr - base - size): addresses below base wrap to a huge offset.
    function automatic logic in_err(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0]   offset;
        logic [ADDR_WIDTH+1:0] diff;
        offset = {1'b0, a} - {1'b0, ERR_BASE};
        diff   = {1'b0, offset} - {2'b00, ERR_SIZE};
        return diff[ADDR_WIDTH+1];
    endfunction

    function automatic logic burst_bad(input logic [7:0] len, input logic [1:0] burst);
        return (burst == 2'b11) ||
               (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [7:0] len,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc  = a + ADDR_WIDTH'(STRB_W);
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << LSB) - ADDR_WIDTH'(1);
        if (burst == 2'b00) return a;
        if (burst == 2'b10 && !burst_bad(len, burst)) return (a & ~mask) | (inc & mask);
        return inc;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic [1:0]            wburst_q, wburst_d, bresp_q, bresp_d;
    logic                  werr_q, werr_d, w_err_beat, mem_we;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;

    r_state_e              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, rd_addr;
    logic [7:0]            rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic [1:0]            rburst_q, rburst_d, rresp_q, rresp_d;
    logic                  rbad_q, rbad_d, rlast_q, rlast_d, rd_load;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  init_q;

    // Ready is withheld until the first edge after reset release.
    assign awready = init_q && (w_state_q == W_IDLE);
    assign wready  = (w_state_q == W_DATA);
    assign bvalid  = (w_state_q == W_RESP);
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = init_q && (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_DATA);
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_d  = w_state_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wbeat_d    = wbeat_q;
        wburst_d   = wburst_q;
        werr_d     = werr_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        w_err_beat = 1'b0;
        mem_we     = 1'b0;
        case (w_state_q)
            W_IDLE: if (awvalid && awready) begin
                waddr_d   = awaddr & ALIGN_MASK;
                wlen_d    = awlen;
                wburst_d  = awburst;
                wbeat_d   = 8'd0;
                werr_d    = burst_bad(awlen, awburst);
                bid_d     = awid;
                w_state_d = W_DATA;
            end
            W_DATA: if (wvalid) begin
                w_err_beat = in_err(waddr_q) || (wlast != (wbeat_q == wlen_q));
                mem_we     = !in_err(waddr_q);
                werr_d     = werr_q || w_err_beat;
                if (wbeat_q == wlen_q) begin
                    bresp_d   = (werr_q || w_err_beat) ? 2'b10 : 2'b00;
                    w_state_d = W_RESP;
                end else begin
                    waddr_d = next_addr(waddr_q, wlen_q, wburst_q);
                    wbeat_d = wbeat_q + 8'd1;
                end
            end
            W_RESP: if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rbeat_d   = rbeat_q;
        rburst_d  = rburst_q;
        rbad_d    = rbad_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rd_addr   = raddr_q;
        rd_load   = 1'b0;
        case (r_state_q)
            R_IDLE: if (arvalid && arready) begin
                rd_addr   = araddr & ALIGN_MASK;
                rd_load   = 1'b1;
                raddr_d   = rd_addr;
                rlen_d    = arlen;
                rburst_d  = arburst;
                rbeat_d   = 8'd0;
                rbad_d    = burst_bad(arlen, arburst);
                rid_d     = arid;
                rlast_d   = (arlen == 8'd0);
                r_state_d = R_DATA;
            end
            R_DATA: if (rready) begin
                if (rlast_q) begin
                    rlast_d   = 1'b0;
                    r_state_d = R_IDLE;
                end else begin
                    rd_addr = next_addr(raddr_q, rlen_q, rburst_q);
                    rd_load = 1'b1;
                    raddr_d = rd_addr;
                    rbeat_d = rbeat_q + 8'd1;
                    rlast_d = (rbeat_q + 8'd1 == rlen_q);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // The array read sees pre-write contents, so a same-edge write is not forwarded.
        if (rd_load) begin
            rdata_d = in_err(rd_addr) ? '0 : mem[rd_addr[LSB +: IDX_W]];
            rresp_d = (in_err(rd_addr) || rbad_d) ? 2'b10 : 2'b00;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            wburst_q  <= '0;
            werr_q    <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rburst_q  <= '0;
            rbad_q    <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            init_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wbeat_q   <= wbeat_d;
            wburst_q  <= wburst_d;
            werr_q    <= werr_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rbeat_q   <= rbeat_d;
            rburst_q  <= rburst_d;
            rbad_q    <= rbad_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            init_q    <= 1'b1;
        end
    end

    // NOTE: the memory array has no reset; contents survive areset.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[waddr_q[LSB +: IDX_W]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end
endmodule

// File: doc/axi4_slave_mem.md
Name: axi4_slave_mem

Overview:
Synthesisable AXI4 full-protocol slave memory model with configurable data width, ID width, depth and an error-injection address window. It replaces the behavioural VIP slave memory agent where RTL is needed, for example in emulation/FPGA builds or as a bench target behind the interconnect. It supports FIXED, INCR and WRAP bursts, byte strobes, and independent concurrent read and write channels.

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 32, data width in bits; power of 2, 32..512.
ID_WIDTH, 4, AXI ID width; must be >= 1.
MEM_DEPTH, 1024, memory size in DATA_WIDTH words; power of 2.
ERR_BASE, 0, byte base address of the SLVERR window.
ERR_SIZE, 0, byte size of the SLVERR window; 0 disables the window.

Ports:
aclk  in  1  clock; all logic is rising-edge.
areset  in  1  asynchronous reset, active-high.
awid  in  ID_WIDTH  write ID.
awaddr  in  ADDR_WIDTH  write start byte address.
awlen  in  8  beats minus 1.
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP.
awvalid  in  1  AW valid.
awready  out  1  AW ready.
wdata  in  DATA_WIDTH  write data.
wstrb  in  DATA_WIDTH/8  byte enables.
wlast  in  1  last write beat.
wvalid  in  1  W valid.
wready  out  1  W ready.
bid  out  ID_WIDTH  response ID (latched awid).
bresp  out  2  00 OKAY, 10 SLVERR.
bvalid  out  1  B valid.
bready  in  1  B ready.
arid  in  ID_WIDTH  read ID.
araddr  in  ADDR_WIDTH  read start byte address.
arlen  in  8  beats minus 1.
arburst  in  2  burst type, same encoding as awburst.
arvalid  in  1  AR valid.
arready  out  1  AR ready.
rid  out  ID_WIDTH  read ID (latched arid).
rdata  out  DATA_WIDTH  read data.
rresp  out  2  per-beat response.
rlast  out  1  last read beat.
rvalid  out  1  R valid.
rready  in  1  R ready.

Behaviour:
- Reset values: awready, wready, bvalid, arready, rvalid and rlast are 0. bresp, rresp, bid, rid and rdata are 0. Memory contents are not reset.
- awready and arready go to 1 on the first clock edge after areset deasserts.
- Word index: (addr >> log2(DATA_WIDTH/8)) mod MEM_DEPTH. Out-of-range addresses alias; they do not raise an error.
- Transfers are always full width; size signals are absent and unaligned low address bits are ignored.
- Write FSM, states W_IDLE, W_DATA and W_RESP:
  - W_IDLE: awready=1. On the AW handshake, latch id/addr/len/burst, go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes only the bytes enabled by wstrb, then advances the address.
  - The burst ends on beat index awlen. Leave for W_RESP after that beat.
  - W_RESP: bvalid=1. Hold bid and bresp stable until bready, then return to W_IDLE.
  - One outstanding write at a time.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready=1. On the AR handshake, latch id/addr/len/burst, go to R_DATA.
  - The first rvalid appears in the cycle after the AR handshake.
  - A new beat is presented each cycle while rready=1 (back-to-back).
  - rdata, rresp and rlast hold stable while rvalid=1 and rready=0.
  - rlast=1 only on beat arlen. Return to R_IDLE after that handshake.
- Address advance:
  - FIXED: address is constant.
  - INCR: address += DATA_WIDTH/8.
  - WRAP: wraps within an aligned block of (len+1)*DATA_WIDTH/8 bytes.
  - WRAP with len not in {1,3,7,15}, or burst code 11: advance as INCR and set the error flag.
- SLVERR sources:
  - Any beat address inside [ERR_BASE, ERR_BASE+ERR_SIZE): the write beat is dropped; the read beat returns rdata=0.
  - Illegal burst, per the address-advance rules.
  - Write only: wlast differs from (beat==awlen) on any beat.
- Error reporting: write errors are sticky for the burst, giving one bresp=10. Read rresp is per beat.
- Read and write channels run fully independently, so AW and AR may handshake in the same cycle.
- Same-word collision: a read beat loaded at the same edge as a write to that word returns the pre-write data.
- Reset mid-burst: FSMs go to IDLE and outputs take reset values immediately. Beats already written stay in memory.

Test Plan:
- INCR write, awlen=3, addr 0x10, data 0x11,0x22,0x33,0x44, wstrb=F, awid=5; then INCR read, same addr/len, arid=9 -> bresp=00, bid=5; reads return 0x11..0x44 with rresp=00, rid=9, rlast only on beat 4.
- WRAP write, len=3, addr 0x08, data 1,2,3,4 (DATA_WIDTH=32) -> words land at 0x08,0x0C,0x00,0x04; INCR read from 0x00 returns 3,4,1,2.
- Fill 0x20 with 0xFFFFFFFF, then write 0x00000000 with wstrb=0101 -> read returns 0xFF00FF00.
- ERR_BASE=0x1000, ERR_SIZE=0x100:
  - write 0x1000, len=1 -> bresp=10, memory unchanged;
  - read 0x0FFC, len=1 -> beat 1 has rdata=original value, rresp=00; beat 2 has rdata=0, rresp=10;
  - separately, wlast asserted on beat 1 of a len=2 burst -> bresp=10.
- Backpressure:
  - rready toggled every other cycle on a len=7 read -> all 8 beats delivered in order, outputs stable while stalled;
  - bready held low 5 cycles -> bvalid held, awready=0 throughout.
- areset pulsed during beat 3 of a len=7 read -> rvalid=0 asynchronously; the next read completes with OKAY and correct data.
